// File: rtl/div8_pkg.sv
// div8_pkg: shared definitions for the 8-bit restoring divider.
// Optional build macro: DIV8_SIGNED_EN (two's-complement operands).
package div8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DIV8_STEPS    = 8;
  localparam logic [7:0] DIV8_DBZ_QUOT = 8'hFF;

  // Iteration counter start value: one step per quotient bit.
  localparam logic [2:0] DIV8_CNT_INIT = 3'(DIV8_STEPS - 1);

  // Two's-complement negation, used for magnitude and sign fix-up.
  function automatic logic [7:0] neg8(input logic [7:0] v);
    return ~v + 8'd1;
  endfunction

endpackage

// File: rtl/div8_if.sv
// div8_if: request/result handshake bundle for div8.
// Handshake: a pair transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready.
// out_valid/quotient/remainder/dbz stay stable until that transfer.
// state is a debug view of the controller FSM.
interface div8_if;
  import div8_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dbz;
  state_t     state;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, state
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, state
  );

endinterface

// File: rtl/div8_sub8.sv
// sub8: 8-bit subtractor with borrow out; borrow=1 means a < b.
module sub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow
);

  // Single 9-bit subtraction gives difference and borrow together.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div8.sv
// div8: 8-bit restoring divider, one quotient bit per cycle, MSB first.
// Optional build macro: DIV8_SIGNED_EN selects two's-complement operands
// (magnitudes go through the unsigned core, signs fixed up at the end).
module div8
  import div8_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  div8_if.slave bus
);

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic [7:0] acc;       // dividend bits shift out the top, quotient bits in the bottom
  logic [7:0] dvs;       // latched divisor magnitude
  logic [7:0] part;      // partial remainder; always < divisor, so 8 bits hold it
  logic [7:0] quot_q;
  logic [7:0] rem_q;
  logic       dbz_q;

  logic       accept;
  logic       div_zero;
  logic [7:0] a_mag;
  logic [7:0] b_mag;
  logic [8:0] shifted;   // 9-bit partial remainder after shifting in the next bit
  logic [7:0] trial;
  logic       borrow;
  logic       step_ok;
  logic [7:0] part_nx;
  logic [7:0] acc_nx;
  logic [7:0] q_fin;
  logic [7:0] r_fin;

  assign accept   = bus.in_valid && (state == IDLE);
  assign div_zero = (bus.divisor == 8'd0);

`ifdef DIV8_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = bus.dividend[7] ? neg8(bus.dividend) : bus.dividend;
  assign b_mag = bus.divisor[7]  ? neg8(bus.divisor)  : bus.divisor;
  assign q_fin = neg_q ? neg8(acc_nx)  : acc_nx;
  assign r_fin = neg_r ? neg8(part_nx) : part_nx;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fin = acc_nx;
  assign r_fin = part_nx;
`endif

  // One restoring step: shift, trial-subtract, keep difference on success.
  assign shifted = {part, acc[7]};

  sub8 u_sub8 (
    .a      (shifted[7:0]),
    .b      (dvs),
    .diff   (trial),
    .borrow (borrow)
  );

  assign step_ok = shifted[8] | ~borrow;
  assign part_nx = step_ok ? trial : shifted[7:0];
  assign acc_nx  = {acc[6:0], step_ok};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = div_zero ? DONE : BUSY;
      BUSY:    if (cnt == 3'd0) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath: operand capture, iteration, result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 3'd0;
      acc    <= 8'd0;
      dvs    <= 8'd0;
      part   <= 8'd0;
      quot_q <= 8'd0;
      rem_q  <= 8'd0;
      dbz_q  <= 1'b0;
`ifdef DIV8_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= a_mag;
            dvs  <= b_mag;
            part <= 8'd0;
            cnt  <= DIV8_CNT_INIT;
`ifdef DIV8_SIGNED_EN
            neg_q <= bus.dividend[7] ^ bus.divisor[7];
            neg_r <= bus.dividend[7];
`endif
            // Divide by zero skips the iteration and publishes immediately.
            if (div_zero) begin
              quot_q <= DIV8_DBZ_QUOT;
              rem_q  <= bus.dividend;
              dbz_q  <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc  <= acc_nx;
          part <= part_nx;
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            quot_q <= q_fin;
            rem_q  <= r_fin;
            dbz_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_div8.sv
// tb_div8: directed and random checks of div8 against an arithmetic model.
module tb_div8;
  import div8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;
  logic [16:0] exp_q[$];   // {dbz, quotient, remainder}

  // Clock and DUT.
  always #5 clk = ~clk;

  div8_if bus ();

  div8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division from the operand rules.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    int q, r;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
`ifdef DIV8_SIGNED_EN
    q = int'($signed(a)) / int'($signed(b));
    r = int'($signed(a)) % int'($signed(b));
`else
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
`endif
    return {1'b0, 8'(q), 8'(r)};
  endfunction

  // Offer one pair, measure latency, check result, optionally stall the consumer.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input logic [16:0] exp, input string tag);
    int lat;
    logic [16:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, " latency"}, 32'(lat), (b == 8'd0) ? 32'd1 : 32'd9);
    check({tag, " quot"}, 32'(bus.quotient), 32'(e[15:8]));
    check({tag, " rem"},  32'(bus.remainder), 32'(e[7:0]));
    check({tag, " dbz"},  32'(bus.dbz), 32'(e[16]));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        bus.in_valid = 1'b1;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        @(posedge clk); #1;
        check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " hold ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, " hold quot"},  32'(bus.quotient), 32'(e[15:8]));
        check({tag, " hold rem"},   32'(bus.remainder), 32'(e[7:0]));
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, " release state"}, 32'(bus.state), 32'(IDLE));
    check({tag, " release valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " idle quot"}, 32'(bus.quotient), 32'(e[15:8]));
    check({tag, " idle rem"},  32'(bus.remainder), 32'(e[7:0]));
  endtask

  initial begin
    logic [7:0] ra, rb;
    bit seen;

    // Reset.
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = 8'd0;
    bus.divisor   = 8'd0;
    #2 rst = 1'b1;
    #1;
    check("reset state", 32'(bus.state), 32'(IDLE));
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset quot", 32'(bus.quotient), 32'd0);
    check("reset rem", 32'(bus.remainder), 32'd0);
    check("reset dbz", 32'(bus.dbz), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
`ifdef DIV8_SIGNED_EN
    do_div(8'h9C, 8'd7, 0, {1'b0, 8'hF2, 8'hFE}, "s -100/7");
    do_div(8'h80, 8'hFF, 0, {1'b0, 8'h80, 8'h00}, "s -128/-1");
    do_div(8'd100, 8'd7, 0, {1'b0, 8'd14, 8'd2}, "s 100/7");
    do_div(8'hFB, 8'd0, 2, {1'b1, 8'hFF, 8'hFB}, "s -5/0");
    do_div(8'd100, 8'hF9, 4, {1'b0, 8'hF2, 8'd2}, "s 100/-7");
`else
    do_div(8'd100, 8'd7, 0, {1'b0, 8'd14, 8'd2}, "100/7");
    do_div(8'd255, 8'd1, 0, {1'b0, 8'd255, 8'd0}, "255/1");
    do_div(8'd7, 8'd9, 0, {1'b0, 8'd0, 8'd7}, "7/9");
    do_div(8'd0, 8'd5, 0, {1'b0, 8'd0, 8'd0}, "0/5");
    do_div(8'd5, 8'd0, 0, {1'b1, 8'hFF, 8'd5}, "5/0");
    do_div(8'd200, 8'd3, 4, {1'b0, 8'd66, 8'd2}, "200/3 bp");
`endif

    // Reset during BUSY aborts the division.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.dividend  = 8'd124;
    bus.divisor   = 8'd42;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort state", 32'(bus.state), 32'(IDLE));
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort quot", 32'(bus.quotient), 32'd0);
    check("abort rem", 32'(bus.remainder), 32'd0);
    check("abort dbz", 32'(bus.dbz), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort no output", 32'(seen), 32'd0);
    do_div(8'd124, 8'd42, 0, {1'b0, 8'd2, 8'd40}, "124/42 after abort");

    // Randomized pairs against the model.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      do_div(ra, rb, int'($urandom_range(0, 3)), model(ra, rb), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
